// File: rtl/kmeansTypes.sv
// Shared k-means datapath constants used by the centroid lane splitter and merger.
// Widths here define the chunk/cacheline geometry of both directions.
package kmeansTypes;
    localparam int NUM_BANK         = 8;
    localparam int NUM_BANK_BITS    = 3;
    localparam int NUM_CLUSTER_BITS = 8;
    localparam int MAX_DEPTH_BITS   = 10;
    localparam int CL_W             = 512;
    localparam int CHUNK_W          = NUM_BANK * 32;
    localparam int SPLIT_RATIO      = 16 / NUM_BANK;
    localparam int SEL_W            = (SPLIT_RATIO > 1) ? $clog2(SPLIT_RATIO) : 1;
endpackage

// File: rtl/c_lane_merger.sv
// Packs NUM_BANK*32-bit centroid chunks into 512-bit cachelines, zero-padding the final partial line.
// Latency: line valid 1 cycle after its completing chunk is accepted.
// Backpressure: single output register; chunk_ready = ~centroid_cl_valid | cl_ready.
module c_lane_merger
    import kmeansTypes::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CLUSTER_BITS:0]     num_cluster,
    input  logic [MAX_DEPTH_BITS:0]       data_dim,
    input  logic [CHUNK_W-1:0]            centroid_chunk,
    input  logic                          centroid_chunk_valid,
    input  logic                          last_chunk_of_all_centroid,
    output logic                          chunk_ready,
    output logic [CL_W-1:0]               centroid_cl,
    output logic                          centroid_cl_valid,
    output logic                          centroid_cl_last,
    input  logic                          cl_ready,
    output logic [31:0]                   cl_sent_cnt,
    output logic                          last_mismatch
);

    logic [31:0]      total_amt;
    logic [31:0]      rcv_cnt;
    logic [31:0]      cur_total;
    logic [SEL_W-1:0] sel_cnt;
    logic [CL_W-1:0]  asm_line;
    logic [CL_W-1:0]  merged;
    logic             acc;
    logic             drop;
    logic             is_last;
    logic             line_done;

    assign chunk_ready = ~centroid_cl_valid | cl_ready;
    assign acc         = centroid_chunk_valid & chunk_ready;

    // The set length is sampled live only on the first chunk; afterwards the latched copy rules.
    assign cur_total = (rcv_cnt == 32'd0)
                     ? 32'(num_cluster) * 32'(data_dim >> NUM_BANK_BITS)
                     : total_amt;
    assign drop      = (cur_total == 32'd0);
    assign is_last   = (rcv_cnt == cur_total - 32'd1);
    assign line_done = acc & ~drop & ((sel_cnt == SEL_W'(SPLIT_RATIO - 1)) | is_last);

    always_comb begin
        merged = asm_line;
        merged[32'(sel_cnt) * CHUNK_W +: CHUNK_W] = centroid_chunk;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_amt <= '0;
            rcv_cnt   <= '0;
            sel_cnt   <= '0;
        end else if (acc && !drop) begin
            if (rcv_cnt == 32'd0)
                total_amt <= cur_total;
            sel_cnt <= line_done ? '0 : sel_cnt + 1'b1;
            rcv_cnt <= is_last ? '0 : rcv_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            asm_line <= '0;
        else if (acc && !drop)
            asm_line <= line_done ? '0 : merged;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            centroid_cl       <= '0;
            centroid_cl_valid <= 1'b0;
            centroid_cl_last  <= 1'b0;
        end else if (line_done) begin
            centroid_cl       <= merged;
            centroid_cl_valid <= 1'b1;
            centroid_cl_last  <= is_last;
        end else if (cl_ready) begin
            centroid_cl_valid <= 1'b0;
            centroid_cl_last  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cl_sent_cnt <= '0;
        else if (centroid_cl_valid && cl_ready)
            cl_sent_cnt <= cl_sent_cnt + 32'd1;
    end

    // Zero-length sets cannot be framed, so they are flagged like a misplaced end marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_mismatch <= 1'b0;
        else if (acc && (drop || (last_chunk_of_all_centroid != is_last)))
            last_mismatch <= 1'b1;
    end

endmodule

// File: tb/tb_c_lane_merger.sv
// Scoreboard bench for c_lane_merger: expected lines queued at stimulus time, compared at handoff.
module tb_c_lane_merger;
    import kmeansTypes::*;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_CLUSTER_BITS:0] num_cluster = '0;
    logic [MAX_DEPTH_BITS:0]   data_dim = '0;
    logic [CHUNK_W-1:0]        centroid_chunk = '0;
    logic                      centroid_chunk_valid = 1'b0;
    logic                      last_chunk_of_all_centroid = 1'b0;
    logic                      chunk_ready;
    logic [CL_W-1:0]           centroid_cl;
    logic                      centroid_cl_valid;
    logic                      centroid_cl_last;
    logic                      cl_ready = 1'b1;
    logic [31:0]               cl_sent_cnt;
    logic                      last_mismatch;

    typedef struct packed {
        logic [CL_W-1:0] d;
        logic            last;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    c_lane_merger dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .num_cluster                (num_cluster),
        .data_dim                   (data_dim),
        .centroid_chunk             (centroid_chunk),
        .centroid_chunk_valid       (centroid_chunk_valid),
        .last_chunk_of_all_centroid (last_chunk_of_all_centroid),
        .chunk_ready                (chunk_ready),
        .centroid_cl                (centroid_cl),
        .centroid_cl_valid          (centroid_cl_valid),
        .centroid_cl_last           (centroid_cl_last),
        .cl_ready                   (cl_ready),
        .cl_sent_cnt                (cl_sent_cnt),
        .last_mismatch              (last_mismatch)
    );

    always #5 clk = ~clk;

    // Every handoff is matched against the oldest expected line.
    always @(negedge clk) begin
        if (rst_n && centroid_cl_valid && cl_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_line got=%h last=%b", centroid_cl, centroid_cl_last);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (centroid_cl !== e.d || centroid_cl_last !== e.last) begin
                    miscompares++;
                    $display("FAIL line got=%h last=%b exp=%h last=%b",
                             centroid_cl, centroid_cl_last, e.d, e.last);
                end
            end
        end
    end

    task automatic push_line(input logic [CHUNK_W-1:0] hi, input logic [CHUNK_W-1:0] lo,
                             input logic last);
        sb.push_back({hi, lo, last});
    endtask

    // Called at posedge+1; returns at posedge+1 just after the chunk is accepted.
    task automatic send_chunk(input logic [CHUNK_W-1:0] d, input logic lst);
        int waited;
        waited = 0;
        centroid_chunk             = d;
        last_chunk_of_all_centroid = lst;
        centroid_chunk_valid       = 1'b1;
        forever begin
            @(negedge clk);
            if (chunk_ready) break;
            waited++;
            if (waited > 200) begin
                vectors++;
                miscompares++;
                $display("FAIL chunk_accept_timeout got=0 exp=1");
                break;
            end
        end
        @(posedge clk);
        #1;
        centroid_chunk_valid       = 1'b0;
        last_chunk_of_all_centroid = 1'b0;
    endtask

    task automatic wait_drain();
        int waited;
        waited = 0;
        while (sb.size() != 0 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout got=%0d pending exp=0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        vectors += 5;
        if (centroid_cl_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got=%b exp=0", centroid_cl_valid); end
        if (centroid_cl_last !== 1'b0) begin miscompares++; $display("FAIL rst_last got=%b exp=0", centroid_cl_last); end
        if (centroid_cl !== '0) begin miscompares++; $display("FAIL rst_cl got=%h exp=0", centroid_cl); end
        if (cl_sent_cnt !== 32'd0) begin miscompares++; $display("FAIL rst_cnt got=%0d exp=0", cl_sent_cnt); end
        if (last_mismatch !== 1'b0) begin miscompares++; $display("FAIL rst_mismatch got=%b exp=0", last_mismatch); end
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_lines();
        num_cluster = 4;
        data_dim    = 16;
        cl_ready    = 1'b1;
        for (int i = 0; i < 4; i++)
            push_line(CHUNK_W'(2 * i + 2), CHUNK_W'(2 * i + 1), i == 3);
        for (int i = 1; i <= 8; i++)
            send_chunk(CHUNK_W'(i), i == 8);
        wait_drain();
        vectors += 3;
        if (cl_sent_cnt !== 32'd4) begin miscompares++; $display("FAIL full_cnt got=%0d exp=4", cl_sent_cnt); end
        if (last_mismatch !== 1'b0) begin miscompares++; $display("FAIL full_mismatch got=%b exp=0", last_mismatch); end
        if (centroid_cl_valid !== 1'b0) begin miscompares++; $display("FAIL full_idle_valid got=%b exp=0", centroid_cl_valid); end
    endtask

    task automatic test_partial_flush();
        num_cluster = 3;
        data_dim    = 8;
        push_line(CHUNK_W'(10), CHUNK_W'(9), 1'b0);
        push_line('0, CHUNK_W'(11), 1'b1);
        send_chunk(CHUNK_W'(9), 1'b0);
        send_chunk(CHUNK_W'(10), 1'b0);
        send_chunk(CHUNK_W'(11), 1'b1);
        wait_drain();
        vectors++;
        if (cl_sent_cnt !== 32'd6) begin miscompares++; $display("FAIL partial_cnt got=%0d exp=6", cl_sent_cnt); end
    endtask

    task automatic test_backpressure();
        logic [CL_W-1:0] line0;
        int holds;
        holds       = 0;
        line0       = {CHUNK_W'(22), CHUNK_W'(21)};
        num_cluster = 2;
        data_dim    = 16;
        push_line(CHUNK_W'(22), CHUNK_W'(21), 1'b0);
        push_line(CHUNK_W'(24), CHUNK_W'(23), 1'b1);
        cl_ready = 1'b0;
        fork
            begin
                for (int i = 21; i <= 24; i++)
                    send_chunk(CHUNK_W'(i), i == 24);
            end
            begin
                repeat (6) begin
                    @(negedge clk);
                    if (centroid_cl_valid) begin
                        holds++;
                        vectors++;
                        if (chunk_ready !== 1'b0 || centroid_cl !== line0) begin
                            miscompares++;
                            $display("FAIL bp_hold ready=%b got=%h exp=%h", chunk_ready, centroid_cl, line0);
                        end
                    end
                end
                @(posedge clk);
                #1;
                cl_ready = 1'b1;
            end
        join
        wait_drain();
        vectors += 2;
        if (holds < 3) begin miscompares++; $display("FAIL bp_hold_cycles got=%0d exp>=3", holds); end
        if (cl_sent_cnt !== 32'd8) begin miscompares++; $display("FAIL bp_cnt got=%0d exp=8", cl_sent_cnt); end
    endtask

    task automatic test_round_trip();
        logic [CL_W-1:0] src[64];
        bit done;
        done        = 1'b0;
        num_cluster = 16;
        data_dim    = 64;
        for (int j = 0; j < 64; j++) begin
            for (int k = 0; k < 16; k++)
                src[j][k * 32 +: 32] = $urandom;
            push_line(src[j][CL_W-1:CHUNK_W], src[j][CHUNK_W-1:0], j == 63);
        end
        fork
            begin
                for (int j = 0; j < 64; j++) begin
                    send_chunk(src[j][CHUNK_W-1:0], 1'b0);
                    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                    send_chunk(src[j][CL_W-1:CHUNK_W], j == 63);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    cl_ready = ($urandom_range(0, 3) != 0);
                end
                cl_ready = 1'b1;
            end
        join
        wait_drain();
        vectors += 2;
        if (cl_sent_cnt !== 32'd72) begin miscompares++; $display("FAIL rt_cnt got=%0d exp=72", cl_sent_cnt); end
        if (last_mismatch !== 1'b0) begin miscompares++; $display("FAIL rt_mismatch got=%b exp=0", last_mismatch); end
    endtask

    task automatic test_reset_mid_line();
        num_cluster = 1;
        data_dim    = 16;
        send_chunk(CHUNK_W'(31), 1'b0);
        #2 rst_n = 1'b0;
        #1;
        vectors += 4;
        if (centroid_cl_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid got=%b exp=0", centroid_cl_valid); end
        if (centroid_cl !== '0) begin miscompares++; $display("FAIL mid_rst_cl got=%h exp=0", centroid_cl); end
        if (cl_sent_cnt !== 32'd0) begin miscompares++; $display("FAIL mid_rst_cnt got=%0d exp=0", cl_sent_cnt); end
        if (chunk_ready !== 1'b1) begin miscompares++; $display("FAIL mid_rst_ready got=%b exp=1", chunk_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_line(CHUNK_W'(33), CHUNK_W'(32), 1'b1);
        send_chunk(CHUNK_W'(32), 1'b0);
        send_chunk(CHUNK_W'(33), 1'b1);
        wait_drain();
        repeat (3) @(posedge clk);
        #1;
        vectors += 2;
        if (cl_sent_cnt !== 32'd1) begin miscompares++; $display("FAIL mid_rst_lines got=%0d exp=1", cl_sent_cnt); end
        if (last_mismatch !== 1'b0) begin miscompares++; $display("FAIL mid_rst_mismatch got=%b exp=0", last_mismatch); end
    endtask

    task automatic test_protocol_error();
        num_cluster = 2;
        data_dim    = 16;
        push_line(CHUNK_W'(42), CHUNK_W'(41), 1'b0);
        push_line(CHUNK_W'(44), CHUNK_W'(43), 1'b1);
        send_chunk(CHUNK_W'(41), 1'b0);
        vectors++;
        if (last_mismatch !== 1'b0) begin miscompares++; $display("FAIL perr_early got=%b exp=0", last_mismatch); end
        send_chunk(CHUNK_W'(42), 1'b1);
        vectors++;
        if (last_mismatch !== 1'b1) begin miscompares++; $display("FAIL perr_set got=%b exp=1", last_mismatch); end
        send_chunk(CHUNK_W'(43), 1'b0);
        send_chunk(CHUNK_W'(44), 1'b0);
        wait_drain();
        vectors += 2;
        if (last_mismatch !== 1'b1) begin miscompares++; $display("FAIL perr_sticky got=%b exp=1", last_mismatch); end
        if (cl_sent_cnt !== 32'd3) begin miscompares++; $display("FAIL perr_cnt got=%0d exp=3", cl_sent_cnt); end
    endtask

    initial begin
        test_reset();
        test_full_lines();
        test_partial_flush();
        test_backpressure();
        test_round_trip();
        test_reset_mid_line();
        test_protocol_error();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
